seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display. It strobes one digit select at a time and drives the matching segment pattern, with a guard gap between digits to suppress ghosting. Display content is loaded through a valid/ready handshake into a pending register and applied only at frame boundaries, so a frame never shows mixed old and new data. It sits between the display-value producer and the board digit/segment pins.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot (guard + on); must be > BLANK_CYC
BLANK_CYC, 16, guard cycles at slot start with all digits off; must be >= 1
DIG_ACT_LOW, 1, 1 = digit selects active-low (inactive value 8'hFF), 0 = active-high (inactive 8'h00)
SEG_ACT_LOW, 1, 1 = segments active-low, 0 = active-high

Ports:
clk  in  1  system clock
rst  in  1  reset
load_valid  in  1  new display word offered
load_ready  out  1  controller can accept a word
load_data  in  32  nibble i = bits [4i+3:4i] = digit i; digit 7 = most significant
load_dp  in  8  bit i = decimal point of digit i
load_lzb  in  1  leading-zero blanking enable, captured with the word
dig  out  8  one-hot digit select, bit i = digit i
seg  out  8  {dp,g,f,e,d,c,b,a}
frame_done  out  1  one-cycle pulse at the end of each 8-digit frame

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - dig and seg are inactive.
  - load_ready = 1, frame_done = 0.
  - State = GUARD, digit index = 0, slot counter = 0.
  - Display and pending registers are cleared (data 0, dp 0, lzb 0). The pending flag is cleared.
- Reset asserted mid-operation has the same effect on the next edge. Any pending word is dropped.
- All outputs are registered.
- Scan FSM (2 states):
  - GUARD: dig and seg inactive for BLANK_CYC cycles, then go to ON.
  - ON: dig[idx] active and seg = pattern(idx) for CLK_DIV-BLANK_CYC cycles. Then idx increments mod 8 and the FSM returns to GUARD.
  - Slot period = CLK_DIV cycles. Frame period = 8*CLK_DIV cycles.
- Timing after rst release (cycle 0 = first cycle with rst low): dig[0] is active in cycles BLANK_CYC .. CLK_DIV-1.
- Frame boundary (last ON cycle of digit 7 ends):
  - frame_done = 1 for the following single cycle, which is the first GUARD cycle of digit 0.
  - In that same cycle, the pending word is copied to the display register if the pending flag is set.
- Handshake:
  - A transfer occurs on any cycle where load_valid and load_ready are both 1.
  - On transfer: load_data, load_dp and load_lzb are captured into the pending register and the pending flag is set. load_ready = 0 from the next cycle.
  - load_ready returns to 1 in the cycle after the word is applied.
  - While load_ready = 0, load_valid and its data are ignored.
- Decode, active-high values (inverted when SEG_ACT_LOW):
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Hex letters: A=77, b=7C, C=39, d=5E, E=79, F=71.
  - seg[7] = dp bit of the digit.
- Leading-zero blanking: when the display lzb = 1, digit i (i >= 1) shows segments a-g off if nibbles i..7 are all zero.
  - dp is still driven from its dp bit.
  - dig is still strobed, so slot timing does not change.
  - Digit 0 is never blanked.

Optional Feature:
SEG_SCAN_PWM_EN:
- Defined: adds input bright[3:0].
  - Within ON, dig and seg are active only for the first ((CLK_DIV-BLANK_CYC)*(bright+1))>>4 cycles, and inactive for the remainder of ON.
  - FSM timing, frame_done and the handshake are unchanged.
  - bright is sampled at GUARD→ON entry.
  - bright=15 equals full on.
- Undefined: no bright port; full on-time.

Test Plan:
(All scenarios use CLK_DIV=20, BLANK_CYC=4, active-low defaults.)
1. Reset and scan timing: rst=1 for 3 cycles → dig=FF, seg=FF, load_ready=1, frame_done=0. After release:
   - dig=FE in cycles 4-19, dig=FF in 20-23, dig=FD in 24-39.
   - frame_done=1 in cycle 160 only.
2. Load and frame apply: mid-frame, load 32'h87654321 with dp=8'h01, lzb=0 → load_ready=0 next cycle and the old content holds until the frame boundary. Next frame:
   - digit0 seg=79 (1 with dp on).
   - digit7 seg=80.
   - load_ready=1 in the cycle after frame_done.
3. Blanking: load 32'h00000120, lzb=1 → digits 3-7 seg=FF, digit2=F9, digit1=A4, digit0=C0. Then load 0 with lzb=1 → digit0=C0, digits 1-7 seg=FF.
4. Back-pressure: hold load_valid with word A, then word B while load_ready=0 → only A is captured. B is accepted on the first cycle load_ready=1 and shown one frame after A.
5. Reset mid-scan: assert rst during the ON slot of digit 5 with a word pending → next cycle dig=FF, seg=FF, load_ready=1. After release, timing restarts as in scenario 1 and the display shows digits 0-7 all = C0.
6. SEG_SCAN_PWM_EN defined, bright=3 → dig[idx] active for 4 cycles at the start of each 16-cycle ON window. bright=15 → active for all 16 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with frame-aligned display loading.
// Optional macro SEG_SCAN_PWM_EN adds a bright[3:0] input that trims each digit's on-time.
module seg_scan_ctrl #(
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 16,
  parameter bit DIG_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic        load_lzb,
  output logic [7:0]  dig,
  output logic [7:0]  seg,
  output logic        frame_done
`ifdef SEG_SCAN_PWM_EN
  ,
  input  logic [3:0]  bright
`endif
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BLANK_FIRST = CW'(BLANK_CYC);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [7:0]    DIG_OFF     = DIG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]    SEG_OFF     = SEG_ACT_LOW ? 8'hFF : 8'h00;

  typedef enum logic {GUARD, ON} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic          boundary;
  logic          transfer;
  logic          pwm_active;

  logic [31:0] pend_data, disp_data;
  logic [7:0]  pend_dp, disp_dp;
  logic        pend_lzb, disp_lzb;
  logic        pend;

  logic [7:0] zmask;
  logic [3:0] nib;
  logic       blank;
  logic [7:0] dig_on, seg_on, dig_d, seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign transfer = load_valid && load_ready;

  // zmask[i] is set when nibbles i..7 of the shown word are all zero
  always_comb begin
    zmask = '0;
    for (int i = 0; i < 8; i++) begin
      zmask[i] = ((disp_data >> (4 * i)) == 32'd0);
    end
  end

`ifdef SEG_SCAN_PWM_EN
  logic [CW-1:0] on_len, on_len_n;

  always_ff @(posedge clk) begin
    if (rst) on_len <= '0;
    else     on_len <= on_len_n;
  end
`endif

  // Outputs are registered from the next state so they line up with the slot counter
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    boundary = 1'b0;
    unique case (state)
      GUARD: begin
        if (cnt == BLANK_LAST) state_n = ON;
      end
      ON: begin
        if (cnt == SLOT_LAST) begin
          state_n  = GUARD;
          cnt_n    = '0;
          idx_n    = idx + 1'b1;
          boundary = (idx == 3'd7);
        end
      end
      default: state_n = GUARD;
    endcase

`ifdef SEG_SCAN_PWM_EN
    on_len_n = on_len;
    if (state == GUARD && state_n == ON)
      on_len_n = CW'(((CLK_DIV - BLANK_CYC) * (int'(bright) + 1)) >> 4);
    pwm_active = ((cnt_n - BLANK_FIRST) < on_len_n);
`else
    pwm_active = 1'b1;
`endif

    nib    = disp_data[{idx_n, 2'b00} +: 4];
    blank  = disp_lzb && (idx_n != 3'd0) && zmask[idx_n];
    dig_on = '0;
    seg_on = '0;
    if (state_n == ON && pwm_active) begin
      dig_on[idx_n] = 1'b1;
      seg_on = {disp_dp[idx_n], blank ? 7'h00 : hex7(nib)};
    end
    dig_d = DIG_ACT_LOW ? ~dig_on : dig_on;
    seg_d = SEG_ACT_LOW ? ~seg_on : seg_on;
  end

  // A pending word moves to the display only at the digit-7 to digit-0 boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GUARD;
      cnt        <= '0;
      idx        <= '0;
      dig        <= DIG_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
      pend       <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_lzb   <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_lzb   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      dig        <= dig_d;
      seg        <= seg_d;
      frame_done <= boundary;
      load_ready <= transfer ? 1'b0 : !pend;
      if (transfer) begin
        pend_data <= load_data;
        pend_dp   <= load_dp;
        pend_lzb  <= load_lzb;
        pend      <= 1'b1;
      end else if (boundary && pend) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        disp_lzb  <= pend_lzb;
        pend      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=20, BLANK_CYC=4, active-low pins.
// Cycle numbers count from the first cycle after rst is released.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic [7:0]  load_dp = '0;
  logic        load_lzb = 1'b0;
  logic [7:0]  dig;
  logic [7:0]  seg;
  logic        frame_done;
`ifdef SEG_SCAN_PWM_EN
  logic [3:0]  bright = 4'hF;
`endif

  int cyc = 0;
  int compared = 0;
  int failed = 0;

  seg_scan_ctrl #(
    .CLK_DIV(20), .BLANK_CYC(4), .DIG_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .load_lzb(load_lzb),
    .dig(dig), .seg(seg), .frame_done(frame_done)
`ifdef SEG_SCAN_PWM_EN
    , .bright(bright)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    compared++;
    assert (obs === expected)
      else begin
        failed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expected);
      end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data,
                               input logic [7:0] dp, input logic lzb);
    load_valid = valid;
    load_data  = data;
    load_dp    = dp;
    load_lzb   = lzb;
  endtask

  // Advance to the falling edge inside cycle n
  task automatic waitCycle(input int n);
    int guard = 0;
    @(negedge clk);
    while (cyc != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      compared++;
      failed++;
      $display("[TB] FAIL wait_cycle: observed %0d expected %0d", cyc, n);
    end
  endtask

  initial begin
    // reset and scan timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_dig", dig, 8'hFF);
    checkOutput("rst_seg", seg, 8'hFF);
    checkOutput("rst_ready", load_ready, 1);
    checkOutput("rst_fd", frame_done, 0);
    rst = 1'b0;
    waitCycle(3);   checkOutput("t3_dig", dig, 8'hFF);
    waitCycle(4);   checkOutput("t4_dig", dig, 8'hFE);
                    checkOutput("t4_seg", seg, 8'hC0);
    waitCycle(19);  checkOutput("t19_dig", dig, 8'hFE);
    waitCycle(20);  checkOutput("t20_dig", dig, 8'hFF);
    waitCycle(23);  checkOutput("t23_dig", dig, 8'hFF);
    waitCycle(24);  checkOutput("t24_dig", dig, 8'hFD);
    waitCycle(39);  checkOutput("t39_dig", dig, 8'hFD);
    waitCycle(159); checkOutput("t159_fd", frame_done, 0);
                    checkOutput("t159_dig", dig, 8'h7F);
    waitCycle(160); checkOutput("t160_fd", frame_done, 1);
    waitCycle(161); checkOutput("t161_fd", frame_done, 0);

    // load mid-frame, applied at the next frame boundary
    waitCycle(200); applyStimulus(1'b1, 32'h87654321, 8'h01, 1'b0);
    waitCycle(201); applyStimulus(1'b0, 32'h0, 8'h00, 1'b0);
                    checkOutput("ld_ready_low", load_ready, 0);
    waitCycle(230); checkOutput("ld_old_hold", seg, 8'hC0);
    waitCycle(319); checkOutput("ld_ready_319", load_ready, 0);
    waitCycle(320); checkOutput("ld_fd_320", frame_done, 1);
                    checkOutput("ld_ready_320", load_ready, 0);
    waitCycle(321); checkOutput("ld_ready_321", load_ready, 1);
    waitCycle(324); checkOutput("ld_d0_dig", dig, 8'hFE);
                    checkOutput("ld_d0_seg", seg, 8'h79);
    waitCycle(390); checkOutput("ld_d3_seg", seg, 8'h99);
    waitCycle(464); checkOutput("ld_d7_dig", dig, 8'h7F);
                    checkOutput("ld_d7_seg", seg, 8'h80);

    // leading-zero blanking
    waitCycle(482); applyStimulus(1'b1, 32'h00000120, 8'h00, 1'b1);
    waitCycle(483); applyStimulus(1'b0, 32'h0, 8'h00, 1'b0);
                    checkOutput("lz_ready_low", load_ready, 0);
    waitCycle(642); applyStimulus(1'b1, 32'h00000000, 8'h00, 1'b1);
    waitCycle(643); applyStimulus(1'b0, 32'h0, 8'h00, 1'b0);
    waitCycle(644); checkOutput("lz_d0", seg, 8'hC0);
    waitCycle(664); checkOutput("lz_d1", seg, 8'hA4);
    waitCycle(684); checkOutput("lz_d2", seg, 8'hF9);
    waitCycle(704); checkOutput("lz_d3", seg, 8'hFF);
    waitCycle(784); checkOutput("lz_d7", seg, 8'hFF);
                    checkOutput("lz_d7_dig", dig, 8'h7F);
    waitCycle(804); checkOutput("lz0_d0", seg, 8'hC0);
    waitCycle(824); checkOutput("lz0_d1", seg, 8'hFF);
    waitCycle(904); checkOutput("lz0_d5", seg, 8'hFF);

    // back-pressure: A taken, B held off until load_ready returns
    waitCycle(962); applyStimulus(1'b1, 32'h0000000A, 8'h00, 1'b0);
    waitCycle(963); applyStimulus(1'b1, 32'h0000000B, 8'h00, 1'b0);
                    checkOutput("bp_ready_963", load_ready, 0);
    waitCycle(1121); checkOutput("bp_ready_1121", load_ready, 1);
    waitCycle(1122); applyStimulus(1'b0, 32'h0, 8'h00, 1'b0);
                     checkOutput("bp_ready_1122", load_ready, 0);
    waitCycle(1124); checkOutput("bp_show_a", seg, 8'h88);
    waitCycle(1284); checkOutput("bp_show_b", seg, 8'h83);

    // reset mid-scan drops the pending word
    waitCycle(1290); applyStimulus(1'b1, 32'h12345678, 8'hFF, 1'b0);
    waitCycle(1291); applyStimulus(1'b0, 32'h0, 8'h00, 1'b0);
                     checkOutput("mr_ready_low", load_ready, 0);
    waitCycle(1390); checkOutput("mr_d5_dig", dig, 8'hDF);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mr_dig", dig, 8'hFF);
    checkOutput("mr_seg", seg, 8'hFF);
    checkOutput("mr_ready", load_ready, 1);
    checkOutput("mr_fd", frame_done, 0);
    rst = 1'b0;
    waitCycle(4);   checkOutput("mr_t4_dig", dig, 8'hFE);
                    checkOutput("mr_t4_seg", seg, 8'hC0);
    waitCycle(20);  checkOutput("mr_t20_dig", dig, 8'hFF);
    waitCycle(24);  checkOutput("mr_t24_dig", dig, 8'hFD);
    waitCycle(160); checkOutput("mr_fd_160", frame_done, 1);
    waitCycle(164); checkOutput("mr_f1_d0", seg, 8'hC0);
    waitCycle(304); checkOutput("mr_f1_d7", seg, 8'hC0);
                    checkOutput("mr_f1_d7_dig", dig, 8'h7F);

`ifdef SEG_SCAN_PWM_EN
    // dimmed on-time window
    waitCycle(310); bright = 4'd3;
    waitCycle(324); checkOutput("pwm_324", dig, 8'hFE);
    waitCycle(327); checkOutput("pwm_327", dig, 8'hFE);
    waitCycle(328); checkOutput("pwm_328", dig, 8'hFF);
                    checkOutput("pwm_328_seg", seg, 8'hFF);
    waitCycle(339); checkOutput("pwm_339", dig, 8'hFF);
    waitCycle(340); bright = 4'd15;
    waitCycle(359); checkOutput("pwm_full_359", dig, 8'hFD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
